// File: rtl/event_packer.sv
// rtl/event_packer.sv - packs channel grants and scan-cycle markers into an 8-deep word FIFO
module event_packer (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic [15:0] ch_sel_i,
  input  logic        zero_i,
  input  logic        cycle_done_i,
  input  logic        enable_i,
  input  logic        clear_i,
  input  logic        rd_ready_i,
  output logic [15:0] data_o,
  output logic        valid_o,
  output logic [3:0]  level_o,
  output logic        overflow_o,
  output logic        onehot_err_o
);

  typedef enum logic {IDLE, PEND} state_t;

  localparam logic [3:0] DEPTH = 4'd8;

  state_t      state;
  logic [10:0] ts;
  logic [3:0]  count;
  logic [3:0]  snap_count;
  logic [10:0] snap_ts;
  logic        overflow;
  logic        onehot_err;

  logic [15:0] mem [8];
  logic [2:0]  wr_ptr;
  logic [2:0]  rd_ptr;
  logic [3:0]  level;

  logic        capture;
  logic        multi_hot;
  logic [3:0]  ch_idx;
  logic [3:0]  count_next;
  logic        done;
  logic        full;
  logic        empty;
  logic        pop;
  logic        marker_try;
  logic        push_req;
  logic        push_ok;
  logic        event_drop;
  logic [15:0] push_word;

  // Lowest set grant bit wins when more than one channel is flagged
  always_comb begin
    ch_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (ch_sel_i[i]) ch_idx = 4'(i);
    end
  end

  // Capture, marker arbitration and FIFO handshake decode
  always_comb begin
    capture    = enable_i && !zero_i && (ch_sel_i != 16'h0000);
    multi_hot  = (ch_sel_i & (ch_sel_i - 16'd1)) != 16'h0000;
    count_next = count;
    if (capture && count != 4'd15) count_next = count + 4'd1;
    done       = enable_i && cycle_done_i;
    full       = (level == DEPTH);
    empty      = (level == 4'd0);
    pop        = !empty && rd_ready_i;
    marker_try = (state == PEND) && !capture;
    push_req   = capture || marker_try;
    push_ok    = push_req && (!full || pop) && !clear_i;
    event_drop = capture && full && !pop;
    push_word  = capture ? {1'b0, ch_idx, ts} : {1'b1, snap_count, snap_ts};
  end

  // Timestamp, per-cycle count, marker FSM and sticky flags
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state      <= IDLE;
      ts         <= '0;
      count      <= '0;
      snap_count <= '0;
      snap_ts    <= '0;
      overflow   <= 1'b0;
      onehot_err <= 1'b0;
    end else if (clear_i) begin
      state      <= IDLE;
      ts         <= '0;
      count      <= '0;
      snap_count <= '0;
      snap_ts    <= '0;
      overflow   <= 1'b0;
      onehot_err <= 1'b0;
    end else begin
      if (enable_i) ts <= ts + 11'd1;
      count <= done ? 4'd0 : count_next;
      if (capture && multi_hot) onehot_err <= 1'b1;
      if (event_drop) overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (done) begin
            state      <= PEND;
            snap_count <= count_next;
            snap_ts    <= ts;
          end
        end
        PEND: begin
          // A second scan end before the old marker lands loses the new one
          if (done) overflow <= 1'b1;
          if (marker_try && push_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 3'd1;
      if (pop)     rd_ptr <= rd_ptr + 3'd1;
      if (push_ok && !pop)      level <= level + 4'd1;
      else if (!push_ok && pop) level <= level - 4'd1;
    end
  end

  // FIFO storage; contents are meaningless once the level drops to zero
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

  assign data_o       = empty ? 16'h0000 : mem[rd_ptr];
  assign valid_o      = !empty;
  assign level_o      = level;
  assign overflow_o   = overflow;
  assign onehot_err_o = onehot_err;

endmodule

// File: doc/event_packer.md
EVENT_PACKER -- requirements
Module: event_packer

Interface
REQ-001 SHALL expose clk_i  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL expose resetn_i  input  1  asynchronous, active-low reset.
REQ-003 SHALL expose ch_sel_i  input  16  one-hot grant from the upstream priority FSM; bit n = channel n.
REQ-004 SHALL expose zero_i  input  1  upstream "no channel" flag; suppresses event capture when high.
REQ-005 SHALL expose cycle_done_i  input  1  single-cycle pulse marking the end of an upstream scan cycle.
REQ-006 SHALL expose enable_i  input  1  capture enable; gates capture and timestamp counting.
REQ-007 SHALL expose clear_i  input  1  synchronous flush of FIFO, flags and counters.
REQ-008 SHALL expose rd_ready_i  input  1  consumer ready.
REQ-009 SHALL expose data_o  output  16  FIFO head word.
REQ-010 SHALL expose valid_o  output  1  head word valid.
REQ-011 SHALL expose level_o  output  4  FIFO occupancy, 0..8.
REQ-012 SHALL expose overflow_o  output  1  sticky: a word or marker was dropped.
REQ-013 SHALL expose onehot_err_o  output  1  sticky: ch_sel_i had more than one bit set.

Function
REQ-014 SHALL keep an 11-bit timestamp ts: +1 per clock while enable_i=1; frozen while enable_i=0; wraps 2047->0.
REQ-015 SHALL capture an event when enable_i=1, zero_i=0 and ch_sel_i!=0.
REQ-016 SHALL format an event word as [15]=0, [14:11]=channel index, [10:0]=ts value at the sampling edge, taken before the increment.
REQ-017 SHALL encode the lowest set bit when ch_sel_i is not one-hot, and set onehot_err_o.
REQ-018 SHALL keep a 4-bit per-cycle event count: +1 per captured event, saturating at 15.
REQ-019 SHALL, on cycle_done_i=1 with enable_i=1, snapshot count (including any event captured in the same cycle) and ts, then zero count.
REQ-020 SHALL format a marker word as [15]=1, [14:11]=snapshot count, [10:0]=snapshot ts.
REQ-021 SHALL run a 2-state marker FSM: IDLE -> PEND on cycle_done_i; PEND -> IDLE on the first cycle with no event capture, during which the marker is written.
REQ-022 SHALL give events write priority over a pending marker; the marker stays in PEND until a cycle with no event capture.
REQ-023 SHALL, on cycle_done_i while in PEND, drop the new marker, set overflow_o and keep the older snapshot.
REQ-024 SHALL use an 8-entry FIFO with at most one write per cycle.
REQ-025 SHALL NOT fall through: a word written at edge N appears on data_o/valid_o after edge N.
REQ-026 SHALL drive valid_o = (level_o!=0); a pop occurs on valid_o=1 and rd_ready_i=1.
REQ-027 SHALL accept a write when the FIFO is full only if a pop occurs in the same cycle; level_o then stays 8.
REQ-028 SHALL, otherwise when full, drop the write and set overflow_o.
REQ-029 SHALL hold a marker in PEND (no drop) while the FIFO is full, retrying each cycle.
REQ-030 SHALL ignore rd_ready_i when the FIFO is empty; level_o SHALL NOT underflow.
REQ-031 SHALL let reads continue while enable_i=0.
REQ-032 SHALL, on clear_i=1, flush the FIFO and zero ts, count, FSM state and sticky flags; all other inputs are ignored that cycle.
REQ-033 SHALL give clear_i priority over all other inputs.

Reset
REQ-034 SHALL, while resetn_i=0, immediately drive level_o=0, valid_o=0, data_o=16'h0000, overflow_o=0 and onehot_err_o=0.
REQ-035 SHALL, while resetn_i=0, hold ts=0, count=0 and FSM=IDLE.
REQ-036 SHALL discard FIFO contents and any pending marker on reset assertion mid-operation.
REQ-037 SHALL behave as after clear_i on the first edge following reset release.

Verification
REQ-038 SHALL cover: after reset, enable_i=1; ch_sel_i=16'h0008 at ts=5 -> data_o=16'h1805, valid_o=1 next cycle.
REQ-039 SHALL cover: ch_sel_i=16'h8000 with cycle_done_i in the same cycle at ts=9 -> event 16'h7809, then marker 16'h8809 one cycle later.
REQ-040 SHALL cover: ch_sel_i=16'h0014 -> channel 2 encoded, onehot_err_o=1 and stays 1 until clear_i.
REQ-041 SHALL cover: rd_ready_i=0 with 9 events -> level_o=8, overflow_o=1, the 9th word is absent.
REQ-042 SHALL cover: full FIFO with simultaneous push and pop -> level_o stays 8, no overflow.
REQ-043 SHALL cover: ts run from 2046 across the wrap -> words carry 2046, 2047, 0; resetn_i pulsed mid-stream -> outputs return to reset values immediately.
